// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-ROM request/response bus between the fetch stage and the ROM.
//
// Signals:
//   rom_en     request strobe, driven by the fetch stage
//   rom_addr   fetch address; held steady while a request waits for rom_ready
//   rom_rdata  instruction word returned by the ROM, valid with rom_ready
//   rom_ready  completion strobe from the ROM
//
// Modports:
//   master  fetch-stage side (drives the request, receives the data)
//   slave   ROM side (receives the request, drives the data)
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [INST_WIDTH-1:0] rom_rdata;
    logic                  rom_ready;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_rdata,
        input  rom_ready
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_rdata,
        output rom_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the PC, issues requests to the instruction
// ROM, parks a completed fetch while the pipeline is stalled, keeps branch
// redirects pending until the PC next advances, and registers the fetched
// instruction into the IF/ID boundary.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   stall_pc       hold the PC (pipeline controller)
//   stall_if       hold the IF/ID output registers (pipeline controller)
//   branch_flag    one-cycle redirect pulse from ID
//   branch_target  redirect address, valid with branch_flag
//   romBus         instruction-ROM bus (fetch_stage_if.master)
//   stall_request  rom_en & ~rom_ready; asks the controller to stall
//   if_pc          PC of if_inst
//   if_inst        fetched instruction, 0 (NOP) when not valid
//   if_valid       if_inst holds a real instruction
//   if_adel        (IF_ADDR_CHECK_EN only) misaligned fetch address
//
// Build option:
//   IF_ADDR_CHECK_EN  when defined, a fetch address with pc[1:0]!=0 makes no
//                     ROM access and is reported through if_adel instead.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_pc,
    input  logic                  stall_if,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    fetch_stage_if.master         romBus,
    output logic                  stall_request,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
`ifdef IF_ADDR_CHECK_EN
    output logic                  if_adel,
`endif
    output logic                  if_valid
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_branchPending;
    logic [ADDR_WIDTH-1:0] r_pendingTarget;
    logic [INST_WIDTH-1:0] r_holdBuf;
    logic [ADDR_WIDTH-1:0] r_holdPc;
    logic [ADDR_WIDTH-1:0] r_ifPc;
    logic [INST_WIDTH-1:0] r_ifInst;
    logic                  r_ifValid;

    logic                  w_romEn;
    logic                  w_advance;
    logic                  w_present;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_presentPc;
    logic [INST_WIDTH-1:0] w_presentInst;
    logic [ADDR_WIDTH-1:0] w_nextPc;
`ifdef IF_ADDR_CHECK_EN
    logic                  w_presentAdel;
    logic                  r_ifAdel;
`endif

    // A branch in the same cycle as the advance wins over an older pending
    // redirect; with neither, fetch continues sequentially (wrapping).
    assign w_nextPc = branch_flag     ? branch_target   :
                      r_branchPending ? r_pendingTarget :
                                        r_pc + ADDR_WIDTH'(4);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and control decode. Completion is judged on rom_ready
    // alone, so stall_request feeding back into stall_pc never closes a
    // combinational loop: stall_pc only chooses between advancing and
    // parking the word in the hold buffer.
    always_comb begin
        w_stateNext   = r_state;
        w_romEn       = 1'b0;
        w_advance     = 1'b0;
        w_present     = 1'b0;
        w_capture     = 1'b0;
        w_presentPc   = r_pc;
        w_presentInst = '0;
`ifdef IF_ADDR_CHECK_EN
        w_presentAdel = 1'b0;
`endif
        case (r_state)
            S_BOOT: begin
                w_stateNext = S_FETCH;
            end
            S_FETCH: begin
`ifdef IF_ADDR_CHECK_EN
                if (r_pc[1:0] != 2'b00) begin
                    if (!stall_pc) begin
                        w_advance     = 1'b1;
                        w_present     = 1'b1;
                        w_presentAdel = 1'b1;
                    end
                end else
`endif
                begin
                    w_romEn = 1'b1;
                    if (romBus.rom_ready) begin
                        if (!stall_pc) begin
                            w_advance     = 1'b1;
                            w_present     = 1'b1;
                            w_presentInst = romBus.rom_rdata;
                        end else begin
                            w_capture   = 1'b1;
                            w_stateNext = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall_pc) begin
                    w_advance     = 1'b1;
                    w_present     = 1'b1;
                    w_presentPc   = r_holdPc;
                    w_presentInst = r_holdBuf;
                    w_stateNext   = S_FETCH;
                end
            end
            default: begin
                w_stateNext = S_BOOT;
            end
        endcase
    end

    // PC, pending redirect and hold buffer. A redirect arriving while the
    // PC is stuck is remembered (latest one wins) and consumed by the next
    // advance; it never disturbs the access already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc            <= RESET_PC;
            r_branchPending <= 1'b0;
            r_pendingTarget <= '0;
            r_holdBuf       <= '0;
            r_holdPc        <= '0;
        end else begin
            if (w_advance) begin
                r_pc            <= w_nextPc;
                r_branchPending <= 1'b0;
            end else if (branch_flag) begin
                r_branchPending <= 1'b1;
                r_pendingTarget <= branch_target;
            end
            if (w_capture) begin
                r_holdBuf <= romBus.rom_rdata;
                r_holdPc  <= r_pc;
            end
        end
    end

    // IF/ID boundary registers. Frozen entirely under stall_if; otherwise a
    // cycle with nothing to present inserts a bubble but keeps the old PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifPc    <= '0;
            r_ifInst  <= '0;
            r_ifValid <= 1'b0;
`ifdef IF_ADDR_CHECK_EN
            r_ifAdel  <= 1'b0;
`endif
        end else if (!stall_if) begin
            if (w_present) begin
                r_ifPc    <= w_presentPc;
                r_ifInst  <= w_presentInst;
                r_ifValid <= 1'b1;
`ifdef IF_ADDR_CHECK_EN
                r_ifAdel  <= w_presentAdel;
`endif
            end else begin
                r_ifInst  <= '0;
                r_ifValid <= 1'b0;
`ifdef IF_ADDR_CHECK_EN
                r_ifAdel  <= 1'b0;
`endif
            end
        end
    end

    assign romBus.rom_en   = w_romEn;
    assign romBus.rom_addr = r_pc;
    assign stall_request   = w_romEn & ~romBus.rom_ready;
    assign if_pc           = r_ifPc;
    assign if_inst         = r_ifInst;
    assign if_valid        = r_ifValid;
`ifdef IF_ADDR_CHECK_EN
    assign if_adel         = r_ifAdel;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: a directed per-cycle vector table,
// hand-written reset / misaligned sequences, and a randomized run scored
// against a transaction-level model of the fetch stream.
// Defining IF_ADDR_CHECK_EN also exercises the if_adel output.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_pc;
    logic        stall_if;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        stall_request;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef IF_ADDR_CHECK_EN
    logic        if_adel;
`endif

    fetch_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) romBus ();

    fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (stall_pc),
        .stall_if      (stall_if),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .romBus        (romBus),
        .stall_request (stall_request),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
`ifdef IF_ADDR_CHECK_EN
        .if_adel       (if_adel),
`endif
        .if_valid      (if_valid)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // The controller always raises stall_pc together with stall_if; flag
    // any cycle where an instruction would be dropped by breaking that.
    always @(posedge clk) begin
        if (rst && stall_if && !stall_pc && romBus.rom_en && romBus.rom_ready) begin
            failures++;
            $display("[TB] FAIL stall_if_without_stall_pc: got 1, expected 0");
        end
    end

    // Contents of the modelled ROM: a fixed scramble of the address.
    function automatic logic [31:0] romData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic bf,
                                 input logic [31:0] bt, input logic rdy);
        stall_pc            = stall;
        stall_if            = stall;
        branch_flag         = bf;
        branch_target       = bt;
        romBus.rom_ready    = rdy;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        romBus.rom_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        bf;
        logic [31:0] bt;
        logic        rdy;
        logic        expEn;
        logic [31:0] expAddr;
        logic        expSr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic stall, logic bf, logic [31:0] bt, logic rdy,
                                   logic expEn, logic [31:0] expAddr, logic expSr,
                                   logic expValid, logic [31:0] expPc, logic [31:0] expInst);
        vec_t v;
        v.stall = stall; v.bf = bf; v.bt = bt; v.rdy = rdy;
        v.expEn = expEn; v.expAddr = expAddr; v.expSr = expSr;
        v.expValid = expValid; v.expPc = expPc; v.expInst = expInst;
        vecs.push_back(v);
    endfunction

    // ---------------- random-phase reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    fetch_t      doneQ[$];
    logic [31:0] expNext;
    bit          haveBranch;
    logic [31:0] branchTgt;
    bit          prevWaiting;
    logic [31:0] prevAddr;
    logic        prevValid;
    logic [31:0] prevPc;
    logic [31:0] prevInst;

    // One cycle of random traffic, entered and left at a falling edge.
    // The model tracks completed-but-undelivered fetches in doneQ and the
    // address the next new request must carry in expNext.
    task automatic randomCycle(input bit noStall);
        logic        stall, bf, en, rdy, deliver, expValid;
        logic [31:0] bt, addr;
        fetch_t      item;
        stall = noStall ? 1'b0 : ($urandom_range(0, 3) == 0);
        bf    = ($urandom_range(0, 5) == 0);
        bt    = $urandom() & 32'hFFFFFFFC;
        applyStimulus(stall, bf, bt, 1'b0);
        #1;
        en   = romBus.rom_en;
        addr = romBus.rom_addr;
        if (doneQ.size() != 0) checkOutput("rnd_no_req_while_held", {31'b0, en}, 32'd0);
        if (prevWaiting) begin
            checkOutput("rnd_req_stable_en", {31'b0, en}, 32'd1);
            checkOutput("rnd_req_stable_addr", addr, prevAddr);
        end else if (en) begin
            checkOutput("rnd_next_addr", addr, expNext);
        end
        rdy = en ? ($urandom_range(0, 2) != 0) : 1'b0;
        romBus.rom_ready = rdy;
        romBus.rom_rdata = romData(addr);
        #1;
        checkOutput("rnd_stall_request", {31'b0, stall_request}, {31'b0, en & ~rdy});
        if (en && rdy) begin
            item.pc   = addr;
            item.inst = romData(addr);
            doneQ.push_back(item);
        end
        if (bf) begin
            haveBranch = 1'b1;
            branchTgt  = bt;
        end
        deliver     = !stall && (doneQ.size() != 0);
        prevWaiting = en & ~rdy;
        prevAddr    = addr;
        @(negedge clk);
        expValid = stall ? prevValid : deliver;
        checkOutput("rnd_if_valid", {31'b0, if_valid}, {31'b0, expValid});
`ifdef IF_ADDR_CHECK_EN
        checkOutput("rnd_if_adel", {31'b0, if_adel}, 32'd0);
`endif
        if (stall) begin
            checkOutput("rnd_hold_pc", if_pc, prevPc);
            checkOutput("rnd_hold_inst", if_inst, prevInst);
        end else if (deliver) begin
            item = doneQ.pop_front();
            checkOutput("rnd_if_pc", if_pc, item.pc);
            checkOutput("rnd_if_inst", if_inst, item.inst);
            expNext    = haveBranch ? branchTgt : item.pc + 32'd4;
            haveBranch = 1'b0;
            prevPc     = item.pc;
            prevInst   = item.inst;
        end else begin
            checkOutput("rnd_bubble_inst", if_inst, 32'd0);
            checkOutput("rnd_bubble_pc", if_pc, prevPc);
            prevInst = 32'd0;
        end
        prevValid = expValid;
    endtask

    initial begin : main
        logic [31:0] b;
        b = RESET_PC;

        // stall, bf, bt, rdy | en, addr, sr | valid, pc, inst
        addVec(0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,        1, 1, b,            0, 1, b,            romData(b));
        addVec(0, 0, 32'h0,        0, 1, b + 4,        1, 0, b,            32'h0);
        addVec(0, 0, 32'h0,        0, 1, b + 4,        1, 0, b,            32'h0);
        addVec(0, 0, 32'h0,        0, 1, b + 4,        1, 0, b,            32'h0);
        addVec(0, 0, 32'h0,        1, 1, b + 4,        0, 1, b + 4,        romData(b + 4));
        addVec(0, 0, 32'h0,        1, 1, b + 8,        0, 1, b + 8,        romData(b + 8));
        addVec(1, 0, 32'h0,        1, 1, b + 12,       0, 1, b + 8,        romData(b + 8));
        addVec(1, 0, 32'h0,        0, 0, 32'h0,        0, 1, b + 8,        romData(b + 8));
        addVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, b + 12,       romData(b + 12));
        addVec(0, 1, 32'h80001000, 0, 1, b + 16,       1, 0, b + 12,       32'h0);
        addVec(0, 0, 32'h0,        0, 1, b + 16,       1, 0, b + 12,       32'h0);
        addVec(0, 0, 32'h0,        1, 1, b + 16,       0, 1, b + 16,       romData(b + 16));
        addVec(1, 1, 32'hA0000000, 1, 1, 32'h80001000, 0, 1, b + 16,       romData(b + 16));
        addVec(1, 1, 32'hA0000040, 0, 0, 32'h0,        0, 1, b + 16,       romData(b + 16));
        addVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h80001000, romData(32'h80001000));
        addVec(0, 0, 32'h0,        1, 1, 32'hA0000040, 0, 1, 32'hA0000040, romData(32'hA0000040));
        addVec(0, 0, 32'h0,        0, 1, 32'hA0000044, 1, 0, 32'hA0000040, 32'h0);

        doReset();
        checkOutput("reset_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("reset_if_pc", if_pc, 32'd0);
        checkOutput("reset_if_inst", if_inst, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stall, vecs[i].bf, vecs[i].bt, vecs[i].rdy);
            #1;
            romBus.rom_rdata = romData(romBus.rom_addr);
            checkOutput($sformatf("vec%0d_rom_en", i), {31'b0, romBus.rom_en}, {31'b0, vecs[i].expEn});
            if (vecs[i].expEn)
                checkOutput($sformatf("vec%0d_rom_addr", i), romBus.rom_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_stall_request", i), {31'b0, stall_request}, {31'b0, vecs[i].expSr});
            @(negedge clk);
            checkOutput($sformatf("vec%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_if_inst", i), if_inst, vecs[i].expInst);
        end

        // Reset in the middle of a ROM wait, then a stray rom_ready.
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("midrst_if_pc", if_pc, 32'd0);
        checkOutput("midrst_if_inst", if_inst, 32'd0);
        checkOutput("midrst_rom_en", {31'b0, romBus.rom_en}, 32'd0);
        checkOutput("midrst_stall_request", {31'b0, stall_request}, 32'd0);
        romBus.rom_ready = 1'b1;
        @(negedge clk);
        checkOutput("midrst_late_ready_valid", {31'b0, if_valid}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_boot_rom_en", {31'b0, romBus.rom_en}, 32'd0);
        checkOutput("midrst_boot_stall_request", {31'b0, stall_request}, 32'd0);
        @(negedge clk);
        checkOutput("midrst_boot_valid", {31'b0, if_valid}, 32'd0);
        #1;
        romBus.rom_rdata = romData(romBus.rom_addr);
        checkOutput("midrst_restart_en", {31'b0, romBus.rom_en}, 32'd1);
        checkOutput("midrst_restart_addr", romBus.rom_addr, RESET_PC);
        @(negedge clk);
        checkOutput("midrst_restart_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("midrst_restart_pc", if_pc, RESET_PC);

`ifdef IF_ADDR_CHECK_EN
        // Branch to a misaligned target: no request, error reported instead.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h80001002, 1'b1);
        #1;
        romBus.rom_rdata = romData(romBus.rom_addr);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("adel_rom_en", {31'b0, romBus.rom_en}, 32'd0);
        checkOutput("adel_stall_request", {31'b0, stall_request}, 32'd0);
        @(negedge clk);
        checkOutput("adel_if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("adel_if_adel", {31'b0, if_adel}, 32'd1);
        checkOutput("adel_if_inst", if_inst, 32'd0);
        checkOutput("adel_if_pc", if_pc, 32'h80001002);
        #1;
        checkOutput("adel_next_addr", romBus.rom_addr, 32'h80001006);
        @(negedge clk);
`endif

        // Randomized traffic against the transaction-level model.
        doReset();
        doneQ.delete();
        expNext     = RESET_PC;
        haveBranch  = 1'b0;
        branchTgt   = 32'h0;
        prevWaiting = 1'b0;
        prevAddr    = 32'h0;
        prevValid   = 1'b0;
        prevPc      = 32'h0;
        prevInst    = 32'h0;
        for (int n = 0; n < 1500; n++) randomCycle(1'b0);
        for (int n = 0; n < 3; n++) randomCycle(1'b1);
        checkOutput("rnd_nothing_dropped", doneQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, drives the instruction-ROM request handshake and registers the fetched instruction into the IF/ID boundary.
- Consumes stall_pc / stall_if from the pipeline controller.
- Produces stall_request, which the top level ORs into the controller's stall_all while a ROM access is outstanding.
- Accepts branch redirects from ID and keeps them pending across stalls and wait states.

Parameters:
- ADDR_WIDTH, 32, PC / ROM address width
- INST_WIDTH, 32, instruction width
- RESET_PC, 32'hBFC00000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall_pc  in  1  hold PC (from pipeline controller)
- stall_if  in  1  hold IF/ID output registers (from pipeline controller)
- branch_flag  in  1  one-cycle redirect pulse from ID
- branch_target  in  ADDR_WIDTH  redirect address, valid with branch_flag
- rom_en  out  1  ROM request
- rom_addr  out  ADDR_WIDTH  ROM address; stable while rom_en=1 and rom_ready=0
- rom_rdata  in  INST_WIDTH  ROM data, valid when rom_ready=1
- rom_ready  in  1  ROM completion strobe
- stall_request  out  1  combinational; =rom_en & ~rom_ready
- if_pc  out  ADDR_WIDTH  registered PC of if_inst
- if_inst  out  INST_WIDTH  registered instruction; 0 (NOP) when invalid
- if_valid  out  1  if_inst is a real instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_BOOT, pc=RESET_PC, branch_pending=0
  - if_pc=0, if_inst=0, if_valid=0, rom_en=0, stall_request=0
  - Asserting rst mid-access abandons the access; a late rom_ready is ignored because state is S_BOOT.
- States:
  - S_BOOT: rom_en=0. Next cycle goes to S_FETCH; reset therefore releases with one dead cycle.
  - S_FETCH: rom_en=1, rom_addr=pc.
    - rom_ready=0: stay; stall_request=1.
    - rom_ready=1 and stall_pc=0: pc <= next_pc; instruction presented to the output registers; stay in S_FETCH (back-to-back fetch, 1 instruction/cycle with a zero-wait ROM).
    - rom_ready=1 and stall_pc=1: rom_rdata captured into hold_buf, hold_pc=pc; go to S_HOLD.
  - S_HOLD: rom_en=0; stall_request=0. When stall_pc=0: pc <= next_pc, hold_buf presented to the output registers; go to S_FETCH.
- next_pc:
  - If branch_flag this cycle: branch_target.
  - Else if branch_pending: pending_target.
  - Else pc+4, modulo 2^ADDR_WIDTH (wraps silently).
- Branch capture:
  - branch_flag in a cycle where the PC does not advance sets branch_pending=1 and pending_target=branch_target.
  - A later branch_flag before consumption overwrites pending_target.
  - branch_pending clears on the cycle the PC advances.
  - A redirect never cancels an in-flight ROM access; the current access completes and only the next address changes.
- Output registers (update only when stall_if=0; when stall_if=1 all hold):
  - Instruction presented this cycle: if_pc=its pc, if_inst=data, if_valid=1.
  - Nothing presented (waiting, boot, hold not released): if_inst=0, if_valid=0, if_pc holds.
- Simultaneous events:
  - stall_if=1 with rom_ready=1 and stall_pc=0 cannot occur because the controller asserts stall_pc with stall_if. If it does occur, the instruction is dropped; a bench assertion flags this.
  - The stall_request to stall_all to stall_pc loop is acyclic in time: capture uses rom_ready, not stall_pc, as the completion condition.

Optional Feature:
- Macro IF_ADDR_CHECK_EN.
- Defined:
  - Adds output if_adel (1 bit, reset 0), registered with the same update rules as if_valid.
  - When the fetch address has pc[1:0]!=0, no ROM access is made: rom_en=0 for that address. The stage presents if_inst=0, if_valid=1, if_adel=1 on the next output update, then continues at next_pc.
- Undefined:
  - Port absent; pc[1:0] is passed to rom_addr unchecked.

Test Plan:
- Reset release, zero-wait ROM (rom_ready tied 1) -> rom_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; if_valid=1 from the second edge after release.
- ROM waits 3 cycles at BFC00004 -> stall_request=1 for exactly 3 cycles; if_valid=0 for those updates; if_inst=rom data at BFC00004 afterwards.
- stall_pc=stall_if=1 for 2 cycles coinciding with rom_ready -> S_HOLD, rom_en=0; the instruction appears once after release with the correct if_pc; no duplicate and no drop.
- branch_flag with target 80001000 during a 2-cycle ROM wait -> the pending access completes; the next rom_addr is 80001000, not pc+4.
- Two branch_flag pulses (targets A0000000 then A0000040) during one stall -> next fetch is A0000040.
- Assert rst mid-wait, then rom_ready pulses -> outputs zero, ignored; fetch restarts at BFC00000.
- With IF_ADDR_CHECK_EN: branch to 80001002 -> no rom_en for that address; if_adel=1, if_inst=0; next fetch at 80001006.
